// File: rtl/spi_pkg.sv
`default_nettype none
// ============================================================================
// Module  : spi_pkg
// Brief   : Shared constants, FSM encoding and bit-reverse helper for SPI IP.
// Rev     : 1.0 - initial release
// ============================================================================
package spi_pkg;

    localparam int c_mode_cpha  = 0;
    localparam int c_mode_cpol  = 1;
    localparam int c_cmd_lsb    = 2;
    localparam int c_cmd_clr    = 3;
    localparam int c_dout_empty = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_XFER = 2'd2,
        ST_DONE = 2'd3
    } spi_state_e;

    function automatic logic [7:0] rev8(input logic [7:0] b);
        logic [7:0] r;
        for (int i = 0; i < 8; i++) begin
            r[i] = b[7-i];
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/spi_slave_sync.sv
`default_nettype none
// ============================================================================
// Module  : spi_slave_sync
// Brief   : Synchronizes SPI pins into clk and derives sck/ss edge pulses.
// Rev     : 1.0 - initial release
// ============================================================================
module spi_slave_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i_sck,
    input  logic i_ss,
    input  logic i_mosi,
    output logic o_sck_rise,
    output logic o_sck_fall,
    output logic o_ss_fall,
    output logic o_ss_rise,
    output logic o_mosi
);

    logic [SYNC_STAGES-1:0] r_sck_sync;
    logic [SYNC_STAGES-1:0] r_ss_sync;
    logic [SYNC_STAGES-1:0] r_mosi_sync;
    logic                   r_sck_d;
    logic                   r_ss_d;
    logic                   w_sck_s;
    logic                   w_ss_s;

    assign w_sck_s = r_sck_sync[SYNC_STAGES-1];
    assign w_ss_s  = r_ss_sync[SYNC_STAGES-1];
    assign o_mosi  = r_mosi_sync[SYNC_STAGES-1];

    // ss resets deasserted so a held-low pin after reset yields a clean fall.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sck_sync  <= '0;
            r_ss_sync   <= '1;
            r_mosi_sync <= '0;
            r_sck_d     <= 1'b0;
            r_ss_d      <= 1'b1;
        end else begin
            r_sck_sync  <= {r_sck_sync[SYNC_STAGES-2:0], i_sck};
            r_ss_sync   <= {r_ss_sync[SYNC_STAGES-2:0], i_ss};
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], i_mosi};
            r_sck_d     <= w_sck_s;
            r_ss_d      <= w_ss_s;
        end
    end

    assign o_sck_rise = w_sck_s & ~r_sck_d;
    assign o_sck_fall = ~w_sck_s & r_sck_d;
    assign o_ss_fall  = ~w_ss_s & r_ss_d;
    assign o_ss_rise  = w_ss_s & ~r_ss_d;

endmodule
`default_nettype wire

// File: rtl/srl_fifo.sv
`default_nettype none
// ============================================================================
// Module  : srl_fifo
// Brief   : Shift-register FIFO with show-ahead head; push+pop when full OK.
// Rev     : 1.0 - initial release
// ============================================================================
module srl_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty
);

    localparam int c_cw = $clog2(DEPTH + 1);
    localparam int c_aw = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_cw-1:0]  r_count;
    logic [c_aw-1:0]  w_head_idx;
    logic             w_push_ok;
    logic             w_pop_ok;

    assign o_full     = (r_count == c_cw'(DEPTH));
    assign o_empty    = (r_count == '0);
    assign w_pop_ok   = i_pop && !o_empty;
    assign w_push_ok  = i_push && (!o_full || i_pop);
    // Newest entry sits at index 0; the oldest is at count-1.
    assign w_head_idx = o_empty ? '0 : c_aw'(r_count - 1'b1);
    assign o_data     = r_mem[w_head_idx];

    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[0] <= i_data;
            for (int i = 1; i < DEPTH; i++) begin
                r_mem[i] <= r_mem[i-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + c_cw'(w_push_ok) - c_cw'(w_pop_ok);
        end
    end

endmodule
`default_nettype wire

// File: rtl/spi_slave_if.sv
`default_nettype none
// ============================================================================
// Module  : spi_slave_if
// Brief   : SPI target endpoint, all CPOL/CPHA modes, TX/RX FIFOs, status.
// Rev     : 1.0 - initial release
// ============================================================================
module spi_slave_if
    import spi_pkg::*;
#(
    parameter int         SYNC_STAGES = 2,
    parameter logic [7:0] IDLE_BYTE   = 8'hFF,
    parameter int         FIFO_DEPTH  = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] din,
    input  logic       cmd,
    input  logic       wr,
    input  logic       rd,
    output logic [8:0] dout,
    output logic       ack,
    output logic [4:0] status,
    input  logic       spi_sck,
    input  logic       spi_ss,
    input  logic       spi_mosi,
    output logic       spi_miso,
    output logic       spi_miso_oe
);

    spi_state_e r_state;
    spi_state_e w_state_nxt;

    logic [1:0] r_cfg_mode;
    logic       r_cfg_lsb;
    logic [1:0] r_act_mode;
    logic       r_act_lsb;
    logic [7:0] r_tx_shr;
    logic [7:0] r_rx_shr;
    logic [2:0] r_bit_cnt;
    logic       r_tx_idle;
    logic       r_miso;
    logic       r_abort;
    logic       r_underrun;
    logic       r_overrun;
    logic       r_ack;
    logic [8:0] r_dout;

    logic       w_sck_rise, w_sck_fall, w_ss_fall, w_ss_rise, w_mosi_s;
    logic       w_lead, w_trail, w_sample, w_shift;
    logic       w_load_tx, w_rx_push_req, w_abort_set;
    logic       w_tx_pop, w_tx_full, w_tx_empty;
    logic       w_rx_full, w_rx_empty;
    logic [7:0] w_tx_head, w_rx_head, w_tx_byte, w_tx_ord, w_rx_ord;
    logic       w_clr, w_underrun_set, w_overrun_set;

    spi_slave_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk        (clk),
        .rst        (rst),
        .i_sck      (spi_sck),
        .i_ss       (spi_ss),
        .i_mosi     (spi_mosi),
        .o_sck_rise (w_sck_rise),
        .o_sck_fall (w_sck_fall),
        .o_ss_fall  (w_ss_fall),
        .o_ss_rise  (w_ss_rise),
        .o_mosi     (w_mosi_s)
    );

    srl_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (wr),
        .i_data  (din),
        .i_pop   (w_tx_pop),
        .o_data  (w_tx_head),
        .o_full  (w_tx_full),
        .o_empty (w_tx_empty)
    );

    srl_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_rx_push_req),
        .i_data  (w_rx_ord),
        .i_pop   (rd),
        .o_data  (w_rx_head),
        .o_full  (w_rx_full),
        .o_empty (w_rx_empty)
    );

    assign w_lead   = r_act_mode[c_mode_cpol] ? w_sck_fall : w_sck_rise;
    assign w_trail  = r_act_mode[c_mode_cpol] ? w_sck_rise : w_sck_fall;
    assign w_sample = r_act_mode[c_mode_cpha] ? w_trail : w_lead;
    assign w_shift  = r_act_mode[c_mode_cpha] ? w_lead  : w_trail;

    assign w_tx_pop  = w_load_tx & ~w_tx_empty;
    assign w_tx_byte = w_tx_empty ? IDLE_BYTE : w_tx_head;
    assign w_tx_ord  = r_act_lsb ? rev8(w_tx_byte) : w_tx_byte;
    assign w_rx_ord  = r_act_lsb ? rev8(r_rx_shr) : r_rx_shr;

    assign w_clr          = cmd & din[c_cmd_clr];
    // Underrun counts only once the master actually samples filler data,
    // so the speculative prefetch at the end of a frame stays silent.
    assign w_underrun_set = (r_state == ST_XFER) && w_sample &&
                            (r_bit_cnt == 3'd0) && r_tx_idle;
    assign w_overrun_set  = w_rx_push_req & w_rx_full & ~rd;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_load_tx     = 1'b0;
        w_rx_push_req = 1'b0;
        w_abort_set   = 1'b0;
        unique case (r_state)
            ST_IDLE: if (w_ss_fall) w_state_nxt = ST_LOAD;
            ST_LOAD: begin
                w_load_tx   = 1'b1;
                w_state_nxt = ST_XFER;
            end
            ST_XFER: if (w_sample && r_bit_cnt == 3'd7) w_state_nxt = ST_DONE;
            ST_DONE: begin
                w_rx_push_req = 1'b1;
                w_load_tx     = 1'b1;
                w_state_nxt   = ST_XFER;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
        if (r_state != ST_IDLE && w_ss_rise) begin
            w_state_nxt = ST_IDLE;
            w_abort_set = (r_state == ST_XFER) && (r_bit_cnt != 3'd0);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cfg_mode <= 2'd0;
            r_cfg_lsb  <= 1'b0;
            r_act_mode <= 2'd0;
            r_act_lsb  <= 1'b0;
            r_tx_shr   <= 8'h00;
            r_rx_shr   <= 8'h00;
            r_bit_cnt  <= 3'd0;
            r_tx_idle  <= 1'b0;
            r_miso     <= 1'b1;
        end else begin
            if (cmd) begin
                r_cfg_mode <= din[1:0];
                r_cfg_lsb  <= din[c_cmd_lsb];
            end
            if (w_ss_fall) begin
                r_act_mode <= r_cfg_mode;
                r_act_lsb  <= r_cfg_lsb;
            end
            if (w_load_tx) begin
                r_tx_idle <= w_tx_empty;
                r_bit_cnt <= 3'd0;
                // CPHA=0 must present bit7 before the first leading edge.
                if (r_state == ST_LOAD && !r_act_mode[c_mode_cpha]) begin
                    r_miso   <= w_tx_ord[7];
                    r_tx_shr <= {w_tx_ord[6:0], 1'b0};
                end else begin
                    r_tx_shr <= w_tx_ord;
                end
            end else if (r_state == ST_XFER) begin
                if (w_sample) begin
                    r_rx_shr  <= {r_rx_shr[6:0], w_mosi_s};
                    r_bit_cnt <= r_bit_cnt + 3'd1;
                end
                if (w_shift) begin
                    r_miso   <= r_tx_shr[7];
                    r_tx_shr <= {r_tx_shr[6:0], 1'b0};
                end
            end else if (r_state == ST_IDLE) begin
                r_miso <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_abort    <= 1'b0;
            r_underrun <= 1'b0;
            r_overrun  <= 1'b0;
            r_ack      <= 1'b0;
            r_dout     <= {1'b1, 8'h00};
        end else begin
            r_abort    <= w_abort_set    | (r_abort    & ~w_clr);
            r_underrun <= w_underrun_set | (r_underrun & ~w_clr);
            r_overrun  <= w_overrun_set  | (r_overrun  & ~w_clr);
            r_ack      <= wr | rd | cmd;
            r_dout     <= (rd && !w_rx_empty) ? {1'b0, w_rx_head} : {1'b1, 8'h00};
        end
    end

    assign dout        = r_dout;
    assign ack         = r_ack;
    assign status      = {w_tx_full, w_rx_empty, r_abort, r_underrun, r_overrun};
    assign spi_miso    = r_miso;
    assign spi_miso_oe = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_spi_slave_if.sv
`default_nettype none
// ============================================================================
// Module  : tb_spi_slave_if
// Brief   : Directed bench acting as SPI master plus bus host for spi_slave_if.
// Rev     : 1.0 - initial release
// ============================================================================
module tb_spi_slave_if;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] din = 8'h00;
    logic       cmd = 1'b0;
    logic       wr  = 1'b0;
    logic       rd  = 1'b0;
    logic       spi_sck  = 1'b0;
    logic       spi_ss   = 1'b1;
    logic       spi_mosi = 1'b0;
    logic [8:0] dout;
    logic       ack;
    logic [4:0] status;
    logic       spi_miso;
    logic       spi_miso_oe;

    logic       cpol = 1'b0;
    logic       cpha = 1'b0;
    int         n_vec = 0;
    int         n_err = 0;
    logic [7:0] rx_b;
    logic       a;

    spi_slave_if dut (
        .clk         (clk),
        .rst         (rst),
        .din         (din),
        .cmd         (cmd),
        .wr          (wr),
        .rd          (rd),
        .dout        (dout),
        .ack         (ack),
        .status      (status),
        .spi_sck     (spi_sck),
        .spi_ss      (spi_ss),
        .spi_mosi    (spi_mosi),
        .spi_miso    (spi_miso),
        .spi_miso_oe (spi_miso_oe)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [8:0] obs, input logic [8:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_cfg(input logic [3:0] v);
        @(negedge clk);
        cmd = 1'b1;
        din = {4'h0, v};
        @(posedge clk);
        #1;
        cmd = 1'b0;
        cpha = v[0];
        cpol = v[1];
        spi_sck = v[1];
    endtask

    task automatic bus_wr(input logic [7:0] b, output logic ak);
        @(negedge clk);
        wr  = 1'b1;
        din = b;
        @(posedge clk);
        #1;
        wr = 1'b0;
        ak = ack;
    endtask

    task automatic bus_rd(input string tag, input logic [8:0] exp);
        @(negedge clk);
        rd = 1'b1;
        @(posedge clk);
        #1;
        rd = 1'b0;
        check(tag, dout, exp);
    endtask

    task automatic ss_low();
        @(negedge clk);
        spi_ss = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    task automatic ss_high();
        repeat (4) @(negedge clk);
        spi_ss = 1'b1;
        repeat (8) @(negedge clk);
    endtask

    // Half sck period is 4 clk, i.e. sck = clk/8.
    task automatic xfer(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
        rx = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            if (!cpha) begin
                spi_mosi = tx[7-i];
                repeat (4) @(negedge clk);
                rx[7-i] = spi_miso;
                spi_sck = ~cpol;
                repeat (4) @(negedge clk);
                spi_sck = cpol;
            end else begin
                spi_sck  = ~cpol;
                spi_mosi = tx[7-i];
                repeat (4) @(negedge clk);
                rx[7-i] = spi_miso;
                spi_sck = cpol;
                repeat (4) @(negedge clk);
            end
        end
    endtask

    initial begin
        repeat (200000) @(posedge clk);
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        check("rst_miso", 9'(spi_miso), 9'h1);
        check("rst_oe", 9'(spi_miso_oe), 9'h0);
        check("rst_ack", 9'(ack), 9'h0);
        check("rst_dout", dout, 9'h100);
        check("rst_status", 9'(status), 9'h008);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // Mode 0, MSB first
        set_cfg(4'h0);
        bus_wr(8'hA5, a);
        check("t1_wr_ack", 9'(a), 9'h1);
        ss_low();
        check("t1_oe", 9'(spi_miso_oe), 9'h1);
        xfer(8'h3C, 8, rx_b);
        check("t1_miso", 9'(rx_b), 9'h0A5);
        ss_high();
        check("t1_oe_off", 9'(spi_miso_oe), 9'h0);
        bus_rd("t1_rd", 9'h03C);
        check("t1_status", 9'(status), 9'h008);

        // Mode 3, LSB first, 3-byte frame with TX underrun on byte 3
        set_cfg(4'h7);
        bus_wr(8'h01, a);
        bus_wr(8'h80, a);
        ss_low();
        xfer(8'h12, 8, rx_b);
        check("t2_miso0", 9'(rx_b), 9'h080);
        xfer(8'h34, 8, rx_b);
        check("t2_miso1", 9'(rx_b), 9'h001);
        xfer(8'hC0, 8, rx_b);
        check("t2_miso2", 9'(rx_b), 9'h0FF);
        ss_high();
        check("t2_underrun", 9'(status[1]), 9'h1);
        bus_rd("t2_rd0", 9'h048);
        bus_rd("t2_rd1", 9'h02C);
        bus_rd("t2_rd2", 9'h003);
        bus_rd("t2_rd_empty", 9'h100);

        // Modes 1 and 2 back-to-back; flag clear rides along with config
        set_cfg(4'h9);
        check("t3_clr", 9'(status[2:0]), 9'h0);
        bus_wr(8'h3A, a);
        ss_low();
        xfer(8'h55, 8, rx_b);
        check("t3_m1_miso", 9'(rx_b), 9'h03A);
        ss_high();
        set_cfg(4'h2);
        bus_wr(8'hC3, a);
        ss_low();
        xfer(8'hAA, 8, rx_b);
        check("t3_m2_miso", 9'(rx_b), 9'h0C3);
        ss_high();
        bus_rd("t3_rd0", 9'h055);
        bus_rd("t3_rd1", 9'h0AA);
        check("t3_flags", 9'(status[2:0]), 9'h0);

        // Abort after 5 bits, then a clean aligned frame
        set_cfg(4'h8);
        bus_wr(8'h5A, a);
        ss_low();
        xfer(8'hFF, 5, rx_b);
        ss_high();
        check("t4_abort", 9'(status[2]), 9'h1);
        check("t4_rx_empty", 9'(status[3]), 9'h1);
        bus_wr(8'h96, a);
        ss_low();
        xfer(8'h71, 8, rx_b);
        check("t4_miso", 9'(rx_b), 9'h096);
        ss_high();
        bus_rd("t4_rd", 9'h071);

        // RX overrun: 5 bytes into a 4-deep FIFO
        set_cfg(4'h8);
        ss_low();
        xfer(8'h11, 8, rx_b);
        xfer(8'h22, 8, rx_b);
        xfer(8'h33, 8, rx_b);
        xfer(8'h44, 8, rx_b);
        xfer(8'h55, 8, rx_b);
        ss_high();
        check("t5_overrun", 9'(status[0]), 9'h1);
        bus_rd("t5_rd0", 9'h011);
        bus_rd("t5_rd1", 9'h022);
        bus_rd("t5_rd2", 9'h033);
        bus_rd("t5_rd3", 9'h044);
        bus_rd("t5_rd4", 9'h100);
        set_cfg(4'h8);
        check("t5_clr", 9'(status[0]), 9'h0);

        // TX full: 5th write dropped but still acknowledged
        bus_wr(8'h01, a);
        bus_wr(8'h02, a);
        bus_wr(8'h03, a);
        bus_wr(8'h04, a);
        check("t5_tx_full", 9'(status[4]), 9'h1);
        bus_wr(8'h05, a);
        check("t5_full_ack", 9'(a), 9'h1);

        // Asynchronous reset mid-byte
        ss_low();
        xfer(8'hF0, 3, rx_b);
        #2;
        rst = 1'b0;
        #1;
        check("t6_oe", 9'(spi_miso_oe), 9'h0);
        check("t6_status", 9'(status), 9'h008);
        check("t6_miso", 9'(spi_miso), 9'h1);
        spi_ss = 1'b1;
        spi_sck = 1'b0;
        spi_mosi = 1'b0;
        cpol = 1'b0;
        cpha = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        bus_wr(8'hE7, a);
        ss_low();
        xfer(8'h18, 8, rx_b);
        check("t6_miso_after", 9'(rx_b), 9'h0E7);
        ss_high();
        bus_rd("t6_rd", 9'h018);
        check("t6_status_after", 9'(status), 9'h008);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
